// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state enum, the requester-index width computation and
// the one-hot to index conversion used for the data mux and source tag.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Widest grant vector the one-hot helper accepts.
  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int num_req);
    int w;
    if (num_req <= 2) begin
      w = 1;
    end else begin
      w = $clog2(num_req);
    end
    return w;
  endfunction

  // Index of the set bit in a one-hot vector; zero when the vector is empty.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [MAX_ID_W-1:0] idx;
    idx = {MAX_ID_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (onehot[i] ? MAX_ID_W'(i) : {MAX_ID_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake plus FIFO write port.
// master = arbiter side, slave = producers and FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_winc;
  logic [OUT_W-1:0]              fifo_wdata;
  logic                          fifo_wfull;

  modport master (
    input  req_valid, req_data, fifo_wfull,
    output req_ready, grant, fifo_winc, fifo_wdata
  );

  modport slave (
    output req_valid, req_data, fifo_wfull,
    input  req_ready, grant, fifo_winc, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req upward from ptr
// with wrap and reports the first hit as index and one-hot.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index,
  output logic [NUM_REQ-1:0] onehot
);

  logic [ID_W-1:0] cand_s;
  logic            hit_s;

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    index  = {ID_W{1'b0}};
    onehot = {NUM_REQ{1'b0}};
    cand_s = {ID_W{1'b0}};
    hit_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = ID_W'((int'(ptr) + i) % NUM_REQ);
      hit_s  = ~found & req[cand_s];
      index  = hit_s ? cand_s : index;
      found  = found | hit_s;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      onehot[j] = found & (index == ID_W'(j));
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async-FIFO write port
// between NUM_REQ requesters, at most MAX_BURST beats per grant.
// Optional feature macro FIFO_WR_ARB_TAG_EN: prefixes fifo_wdata with the
// source index so the read side can demultiplex by requester.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                wclk,
  input logic                wrst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_r, state_s;
  logic [NUM_REQ-1:0]  grant_r, grant_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]    beat_cnt_r, beat_cnt_s;

  logic                pick_found_s;
  logic [ID_W-1:0]     pick_idx_s;
  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [DATA_WIDTH-1:0] payload_s;
  logic                in_burst_s;
  logic                accept_s;
  logic                gnt_valid_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_r),
    .found  (pick_found_s),
    .index  (pick_idx_s),
    .onehot (pick_oh_s)
  );

  assign in_burst_s  = (state_r == ARB_BURST);
  assign gnt_idx_s   = ID_W'(onehot_to_idx(MAX_REQ'(grant_r)));
  assign accept_s    = |(bus.req_valid & ready_s);
  assign gnt_valid_s = |(bus.req_valid & grant_r);

  // Ready follows the owner and is killed combinationally by a full FIFO;
  // the payload mux selects the owner's slice.
  always_comb begin
    ready_s   = {NUM_REQ{1'b0}};
    payload_s = {DATA_WIDTH{1'b0}};
    if (in_burst_s) begin
      ready_s = grant_r & {NUM_REQ{~bus.fifo_wfull}};
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_idx_s) begin
        payload_s = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        payload_s = payload_s;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.grant     = grant_r;
  assign bus.fifo_winc = accept_s;

`ifdef FIFO_WR_ARB_TAG_EN
  assign bus.fifo_wdata = in_burst_s ? {gnt_idx_s, payload_s} : {(DATA_WIDTH + ID_W){1'b0}};
`else
  assign bus.fifo_wdata = in_burst_s ? payload_s : {DATA_WIDTH{1'b0}};
`endif

  // Next state: arbitrate in IDLE, count beats and detect release in BURST.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          grant_s    = pick_oh_s;
          rr_ptr_s   = (pick_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (pick_idx_s + ID_W'(1));
          beat_cnt_s = {CNT_W{1'b0}};
          state_s    = ARB_BURST;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (!gnt_valid_s) begin
          // Owner went quiet: release even if the FIFO is also full.
          grant_s = {NUM_REQ{1'b0}};
          state_s = ARB_IDLE;
        end else if (accept_s) begin
          beat_cnt_s = beat_cnt_r + CNT_W'(1);
          if (beat_cnt_r == CNT_W'(MAX_BURST - 1)) begin
            grant_s = {NUM_REQ{1'b0}};
            state_s = ARB_IDLE;
          end else begin
            state_s = ARB_BURST;
          end
        end else begin
          // FIFO full with a valid owner: stall, keep the grant.
          state_s = ARB_BURST;
        end
      end
      default: begin
        grant_s    = {NUM_REQ{1'b0}};
        beat_cnt_s = {CNT_W{1'b0}};
        state_s    = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state registers with asynchronous reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r    <= ARB_IDLE;
      grant_r    <= {NUM_REQ{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter. Producers are
// beat queues; a cycle-level reference model tracks owner, beats taken and
// the next search start, and predicts every output each cycle.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = id_w(NUM_REQ);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OUT_W = DATA_WIDTH + ID_W;
`else
  localparam int OUT_W = DATA_WIDTH;
`endif
  localparam int VEC_W = 2*NUM_REQ + 1 + OUT_W;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .OUT_W(OUT_W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DATA_WIDTH-1:0] src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0]    drop_mask;
  logic [OUT_W-1:0]      wr_log[$];
  int                    m_owner, m_ptr, m_beats;
  logic [VEC_W-1:0]      exp_vec, obs_vec;

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_beats   = 0;
    drop_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    wr_log.delete();
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    model_reset();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_wfull = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // One cycle: drive producers, predict outputs, capture outputs, advance model.
  task automatic step(input logic wfull);
    logic [NUM_REQ-1:0]            v, eg, er;
    logic [NUM_REQ*DATA_WIDTH-1:0] d;
    logic                          ew, found;
    logic [OUT_W-1:0]              ed;
    logic [DATA_WIDTH-1:0]         pay;
    int                            k;
    @(negedge wclk);
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (src_q[i].size() > 0) && !drop_mask[i];
      d[i*DATA_WIDTH +: DATA_WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : DATA_WIDTH'($urandom);
    end
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.fifo_wfull = wfull;
    eg = '0; er = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er  = wfull ? '0 : eg;
      ew  = v[m_owner] && !wfull;
      pay = d[m_owner*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_WR_ARB_TAG_EN
      ed  = {ID_W'(m_owner), pay};
`else
      ed  = pay;
`endif
    end
    #1;
    exp_vec = {eg, er, ew, ed};
    obs_vec = {bus.grant, bus.req_ready, bus.fifo_winc, bus.fifo_wdata};
    if (bus.fifo_winc) wr_log.push_back(bus.fifo_wdata);
    if (m_owner < 0) begin
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        k = (m_ptr + j) % NUM_REQ;
        if (!found && v[k]) begin
          found   = 1'b1;
          m_owner = k;
          m_beats = 0;
          m_ptr   = (k + 1) % NUM_REQ;
        end
      end
    end else if (!v[m_owner]) begin
      m_owner = -1;
    end else if (!wfull) begin
      void'(src_q[m_owner].pop_front());
      m_beats++;
      if (m_beats == MAX_BURST) m_owner = -1;
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = NUM_REQ*DATA_WIDTH'($urandom);
    bus.fifo_wfull = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      #1;
      obs_vec = {bus.grant, bus.req_ready, bus.fifo_winc, bus.fifo_wdata};
      chk_cnt++;
      if (obs_vec !== '0) $display("FAIL reset_outputs c%0d: got %h want 0", c, obs_vec);
      else pass_cnt++;
    end
    do_reset();
  endtask

  task automatic test_burst_split();
    logic [8:0] winc_pat;
    winc_pat = 9'b011110110;
    do_reset();
    for (int i = 0; i < 6; i++) src_q[1].push_back(DATA_WIDTH'(32'h10 + i));
    for (int c = 0; c < 9; c++) begin
      step(1'b0);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL split_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      chk_cnt++;
      if (obs_vec[OUT_W] !== winc_pat[8-c]) $display("FAIL split_winc%0d: got %b want %b", c, obs_vec[OUT_W], winc_pat[8-c]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (wr_log.size() != 6) $display("FAIL split_count: got %0d want 6", wr_log.size());
    else pass_cnt++;
    for (int i = 0; i < wr_log.size() && i < 6; i++) begin
      chk_cnt++;
      if (wr_log[i][DATA_WIDTH-1:0] !== DATA_WIDTH'(32'h10 + i))
        $display("FAIL split_data%0d: got %h want %h", i, wr_log[i][DATA_WIDTH-1:0], 32'h10 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    int                 gseq[$];
    int                 exp_seq[5];
    logic [NUM_REQ-1:0] prev_g;
    exp_seq = '{1, 2, 4, 8, 1};
    prev_g  = '0;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int b = 0; b < 8; b++) src_q[i].push_back(DATA_WIDTH'($urandom));
    for (int c = 0; c < 22; c++) begin
      step(1'b0);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL contend_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (obs_vec[VEC_W-1 -: NUM_REQ] != '0 && prev_g == '0) gseq.push_back(int'(obs_vec[VEC_W-1 -: NUM_REQ]));
      prev_g = obs_vec[VEC_W-1 -: NUM_REQ];
    end
    chk_cnt++;
    if (gseq.size() != 5) $display("FAIL contend_grants: got %0d grants want 5", gseq.size());
    else pass_cnt++;
    for (int i = 0; i < gseq.size() && i < 5; i++) begin
      chk_cnt++;
      if (gseq[i] != exp_seq[i]) $display("FAIL contend_seq%0d: got %0d want %0d", i, gseq[i], exp_seq[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (wr_log.size() != 17) $display("FAIL contend_writes: got %0d want 17", wr_log.size());
    else pass_cnt++;
  endtask

  task automatic test_full_stall();
    logic [NUM_REQ-1:0] g0;
    logic               wf;
    g0 = NUM_REQ'(1);
    do_reset();
    for (int i = 0; i < 6; i++) src_q[0].push_back(DATA_WIDTH'($urandom));
    for (int c = 0; c < 9; c++) begin
      wf = (c >= 3 && c <= 5);
      step(wf);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL stall_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (wf) begin
        chk_cnt++;
        if (obs_vec[VEC_W-1 -: 2*NUM_REQ+1] !== {g0, {NUM_REQ{1'b0}}, 1'b0})
          $display("FAIL stall_hold%0d: got %h want grant=%h ready=0 winc=0", c, obs_vec[VEC_W-1 -: 2*NUM_REQ+1], g0);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (wr_log.size() != 4) $display("FAIL stall_writes: got %0d want 4", wr_log.size());
    else pass_cnt++;
    chk_cnt++;
    if (obs_vec[VEC_W-1 -: NUM_REQ] !== '0) $display("FAIL stall_release: got %h want 0", obs_vec[VEC_W-1 -: NUM_REQ]);
    else pass_cnt++;
  endtask

  task automatic test_early_release();
    logic [NUM_REQ-1:0] g3;
    g3 = NUM_REQ'(8);
    do_reset();
    for (int i = 0; i < 2; i++) src_q[2].push_back(DATA_WIDTH'($urandom));
    for (int i = 0; i < 4; i++) src_q[3].push_back(DATA_WIDTH'($urandom));
    for (int c = 0; c < 6; c++) begin
      step(1'b0);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL early_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (c == 4) begin
        chk_cnt++;
        if (obs_vec[VEC_W-1 -: NUM_REQ] !== '0) $display("FAIL early_idle: got %h want 0", obs_vec[VEC_W-1 -: NUM_REQ]);
        else pass_cnt++;
      end
      if (c == 5) begin
        chk_cnt++;
        if (obs_vec[VEC_W-1 -: NUM_REQ] !== g3) $display("FAIL early_next: got %h want %h", obs_vec[VEC_W-1 -: NUM_REQ], g3);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [NUM_REQ-1:0] g0;
    g0 = NUM_REQ'(1);
    do_reset();
    for (int i = 0; i < 6; i++) src_q[0].push_back(DATA_WIDTH'($urandom));
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL midrst_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
    end
    @(negedge wclk);
    bus.req_valid = '1;
    #1 wrst_n = 1'b0;
    #1;
    obs_vec = {bus.grant, bus.req_ready, bus.fifo_winc, bus.fifo_wdata};
    chk_cnt++;
    if (obs_vec !== '0) $display("FAIL midrst_outputs: got %h want 0", obs_vec);
    else pass_cnt++;
    model_reset();
    @(negedge wclk);
    bus.req_valid = '0;
    wrst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      for (int b = 0; b < 2; b++) src_q[i].push_back(DATA_WIDTH'($urandom));
    for (int c = 0; c < 2; c++) begin
      step(1'b0);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL midrst_after%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
    end
    chk_cnt++;
    if (obs_vec[VEC_W-1 -: NUM_REQ] !== g0) $display("FAIL midrst_first_grant: got %h want %h", obs_vec[VEC_W-1 -: NUM_REQ], g0);
    else pass_cnt++;
  endtask

`ifdef FIFO_WR_ARB_TAG_EN
  task automatic test_tag();
    logic [OUT_W-1:0] want;
    want = OUT_W'(10'h2A5);
    do_reset();
    src_q[2].push_back(DATA_WIDTH'(8'hA5));
    step(1'b0);
    step(1'b0);
    chk_cnt++;
    if (obs_vec[OUT_W-1:0] !== want) $display("FAIL tag_wdata: got %h want %h", obs_vec[OUT_W-1:0], want);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic wf;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(3, 0) == 0) src_q[i].push_back(DATA_WIDTH'($urandom));
        drop_mask[i] = ($urandom_range(7, 0) == 0);
      end
      wf = ($urandom_range(3, 0) == 0);
      step(wf);
      chk_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec, exp_vec);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_burst_split();
    test_contention();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
`ifdef FIFO_WR_ARB_TAG_EN
    test_tag();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
